// File: rtl/culsans_axi_sram_slave.sv
// AXI4 slave backed by a 64-bit word SRAM.
// Serves one burst at a time with alternating AW/AR arbitration.

package culsans_pkg;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;

endpackage

module culsans_axi_sram_slave
  import culsans_pkg::*;
#(
  parameter int unsigned NumWords = 512,
  parameter logic [63:0] BaseAddr = 64'h8000_0000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  req_slv_t  axi_req_i,
  output resp_slv_t axi_resp_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam logic [63:0] SpanBytes = 64'(NumWords) << 3;
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        last_wr_q, last_wr_d;

  logic [63:0] mem_q [NumWords];

  logic [63:0]     off;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [63:0]     next_addr;
  logic            beat_last;
  logic            both_v;
  logic            aw_rdy;
  logic            ar_rdy;
  logic            aw_hs;
  logic            ar_hs;
  logic            w_hs;
  logic            unused_ok;

  // Current beat address decode and burst advance
  always_comb begin
    off       = addr_q - BaseAddr;
    in_range  = (addr_q >= BaseAddr) && (off < SpanBytes);
    idx       = off[IdxW+2:3];
    next_addr = (burst_q == BurstFixed) ? addr_q
                                        : addr_q + (64'd1 << size_q);
    beat_last = (cnt_q == len_q);
  end

  // Alternating grant when both address channels request together
  always_comb begin
    both_v = axi_req_i.aw_valid & axi_req_i.ar_valid;
    aw_rdy = (state_q == IDLE) & (~both_v | ~last_wr_q);
    ar_rdy = (state_q == IDLE) & (~both_v | last_wr_q);
    aw_hs  = axi_req_i.aw_valid & aw_rdy;
    ar_hs  = axi_req_i.ar_valid & ar_rdy;
    w_hs   = (state_q == WDATA) & axi_req_i.w_valid;
  end

  // Next-state logic for the transaction FSM
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (aw_hs) begin
          id_d      = axi_req_i.aw.id;
          addr_d    = axi_req_i.aw.addr;
          len_d     = axi_req_i.aw.len;
          size_d    = axi_req_i.aw.size;
          burst_d   = axi_req_i.aw.burst;
          last_wr_d = 1'b1;
          state_d   = WDATA;
        end else if (ar_hs) begin
          id_d      = axi_req_i.ar.id;
          addr_d    = axi_req_i.ar.addr;
          len_d     = axi_req_i.ar.len;
          size_d    = axi_req_i.ar.size;
          burst_d   = axi_req_i.ar.burst;
          last_wr_d = 1'b0;
          state_d   = RDATA;
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (!in_range) err_d = 1'b1;
          if (axi_req_i.w.last != beat_last) err_d = 1'b1;
          if (axi_req_i.w.last || beat_last) begin
            state_d = WRESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      WRESP: begin
        if (axi_req_i.b_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (axi_req_i.r_ready) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and transaction context registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Byte-lane writes; storage is deliberately left untouched by reset
  always_ff @(posedge clk_i) begin
    if (w_hs && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (axi_req_i.w.strb[i]) begin
          mem_q[idx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
        end
      end
    end
  end

  // Response channel assembly
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_rdy;
    axi_resp_o.ar_ready = ar_rdy;
    axi_resp_o.w_ready  = (state_q == WDATA);
    axi_resp_o.b_valid  = (state_q == WRESP);
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = err_q ? RespSlvErr : RespOkay;
    axi_resp_o.r_valid  = (state_q == RDATA);
    axi_resp_o.r.id     = id_q;
    if (state_q == RDATA) begin
      axi_resp_o.r.data = in_range ? mem_q[idx] : '0;
      axi_resp_o.r.resp = in_range ? RespOkay : RespSlvErr;
      axi_resp_o.r.last = beat_last;
    end
  end

  assign unused_ok = ^{axi_req_i.aw.lock, axi_req_i.aw.cache,
                       axi_req_i.aw.prot, axi_req_i.aw.qos,
                       axi_req_i.aw.region, axi_req_i.aw.atop,
                       axi_req_i.aw.user, axi_req_i.w.user,
                       axi_req_i.ar.lock, axi_req_i.ar.cache,
                       axi_req_i.ar.prot, axi_req_i.ar.qos,
                       axi_req_i.ar.region, axi_req_i.ar.user,
                       off[63:IdxW+3], off[2:0]};

endmodule

// File: tb/tb_culsans_axi_sram_slave.sv
// Directed bench for culsans_axi_sram_slave.
// Walks single, burst, strobe, range, arbitration and reset cases.

module tb_culsans_axi_sram_slave;
  import culsans_pkg::*;

  logic      clk;
  logic      rst;
  req_slv_t  req;
  resp_slv_t resp;

  int total = 0;
  int bad = 0;

  culsans_axi_sram_slave dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_resp_o(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL timeout waiting for bench to finish");
    $finish;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic [5:0] id, input logic [63:0] a,
                        input logic [7:0] len);
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = a;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = 2'b01;
  endtask

  task automatic set_ar(input logic [5:0] id, input logic [63:0] a,
                        input logic [7:0] len);
    req.ar       = '0;
    req.ar.id    = id;
    req.ar.addr  = a;
    req.ar.len   = len;
    req.ar.size  = 3'd3;
    req.ar.burst = 2'b01;
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [63:0] a,
                         input logic [7:0] len);
    @(negedge clk);
    set_aw(id, a, len);
    req.aw_valid = 1'b1;
    #1;
    chk("aw_ready", resp.aw_ready, 1'b1);
    @(posedge clk);
    #1 req.aw_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    @(negedge clk);
    req.w.data  = d;
    req.w.strb  = s;
    req.w.last  = l;
    req.w_valid = 1'b1;
    #1;
    chk("w_ready", resp.w_ready, 1'b1);
    @(posedge clk);
    #1 req.w_valid = 1'b0;
  endtask

  task automatic b_get(input logic [5:0] id, input logic [1:0] r);
    @(negedge clk);
    req.b_ready = 1'b1;
    #1;
    chk("b_valid", resp.b_valid, 1'b1);
    chk("b_id", resp.b.id, id);
    chk("b_resp", resp.b.resp, r);
    chk("b_user", resp.b.user, 1'b0);
    @(posedge clk);
    #1 req.b_ready = 1'b0;
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [63:0] a,
                         input logic [7:0] len);
    @(negedge clk);
    set_ar(id, a, len);
    req.ar_valid = 1'b1;
    #1;
    chk("ar_ready", resp.ar_ready, 1'b1);
    @(posedge clk);
    #1 req.ar_valid = 1'b0;
    chk("r_latency", resp.r_valid, 1'b1);
  endtask

  task automatic r_beat(input logic [5:0] id, input logic [63:0] d,
                        input logic [1:0] r, input logic l);
    @(negedge clk);
    req.r_ready = 1'b1;
    #1;
    chk("r_valid", resp.r_valid, 1'b1);
    chk("r_id", resp.r.id, id);
    chk("r_data", resp.r.data, d);
    chk("r_resp", resp.r.resp, r);
    chk("r_last", resp.r.last, l);
    chk("r_user", resp.r.user, 1'b0);
    @(posedge clk);
    #1 req.r_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_aw_ready", resp.aw_ready, 1'b1);
    chk("rst_ar_ready", resp.ar_ready, 1'b1);
    chk("rst_w_ready", resp.w_ready, 1'b0);
    chk("rst_b_valid", resp.b_valid, 1'b0);
    chk("rst_r_valid", resp.r_valid, 1'b0);
    chk("rst_r_data", resp.r.data, 64'h0);
    chk("rst_b_id", resp.b.id, 6'h0);

    @(negedge clk);
    set_aw(6'd1, 64'h8000_0020, 8'd0);
    set_ar(6'd2, 64'h8000_0020, 8'd0);
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    chk("arb1_aw_ready", resp.aw_ready, 1'b1);
    chk("arb1_ar_ready", resp.ar_ready, 1'b0);
    @(posedge clk);
    #1;
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    w_beat(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1);
    b_get(6'd1, 2'b00);

    @(negedge clk);
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    chk("arb2_aw_ready", resp.aw_ready, 1'b0);
    chk("arb2_ar_ready", resp.ar_ready, 1'b1);
    @(posedge clk);
    #1;
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    chk("arb2_r_latency", resp.r_valid, 1'b1);
    r_beat(6'd2, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b1);

    aw_send(6'd5, 64'h8000_0010, 8'd0);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    b_get(6'd5, 2'b00);
    ar_send(6'd5, 64'h8000_0010, 8'd0);
    r_beat(6'd5, 64'h1122_3344_5566_7788, 2'b00, 1'b1);

    aw_send(6'd3, 64'h8000_0000, 8'd3);
    for (int k = 0; k < 4; k++) w_beat(64'(k), 8'hFF, k == 3);
    b_get(6'd3, 2'b00);
    ar_send(6'd4, 64'h8000_0000, 8'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req.r_ready = 1'b0;
      #1;
      chk("stall_valid_a", resp.r_valid, 1'b1);
      chk("stall_data_a", resp.r.data, 64'(k));
      @(posedge clk);
      #1;
      chk("stall_valid_b", resp.r_valid, 1'b1);
      chk("stall_data_b", resp.r.data, 64'(k));
      chk("stall_last_b", resp.r.last, k == 3);
      r_beat(6'd4, 64'(k), 2'b00, k == 3);
    end

    aw_send(6'd6, 64'h8000_0100, 8'd0);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_get(6'd6, 2'b00);
    aw_send(6'd6, 64'h8000_0100, 8'd0);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_get(6'd6, 2'b00);
    ar_send(6'd6, 64'h8000_0100, 8'd0);
    r_beat(6'd6, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);

    aw_send(6'd9, 64'h8000_0FF8, 8'd0);
    w_beat(64'hA5A5_5A5A_A5A5_5A5A, 8'hFF, 1'b1);
    b_get(6'd9, 2'b00);
    ar_send(6'd9, 64'h8000_0FF8, 8'd1);
    r_beat(6'd9, 64'hA5A5_5A5A_A5A5_5A5A, 2'b00, 1'b0);
    r_beat(6'd9, 64'h0, 2'b10, 1'b1);

    aw_send(6'd10, 64'h7FFF_FFF8, 8'd0);
    w_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
    b_get(6'd10, 2'b10);
    ar_send(6'd11, 64'h8000_0FF8, 8'd0);
    r_beat(6'd11, 64'hA5A5_5A5A_A5A5_5A5A, 2'b00, 1'b1);
    ar_send(6'd11, 64'h8000_0000, 8'd0);
    r_beat(6'd11, 64'h0, 2'b00, 1'b1);

    aw_send(6'd12, 64'h8000_0300, 8'd1);
    w_beat(64'h77, 8'hFF, 1'b1);
    b_get(6'd12, 2'b10);

    aw_send(6'd13, 64'h8000_0200, 8'd7);
    for (int k = 0; k < 8; k++) w_beat(64'h100 + 64'(k), 8'hFF, k == 7);
    b_get(6'd13, 2'b00);
    ar_send(6'd14, 64'h8000_0200, 8'd7);
    r_beat(6'd14, 64'h100, 2'b00, 1'b0);
    r_beat(6'd14, 64'h101, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_beat2_data", resp.r.data, 64'h102);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_r_valid", resp.r_valid, 1'b0);
    chk("mid_aw_ready", resp.aw_ready, 1'b1);
    chk("mid_ar_ready", resp.ar_ready, 1'b1);
    chk("mid_b_valid", resp.b_valid, 1'b0);
    ar_send(6'd15, 64'h8000_0210, 8'd0);
    r_beat(6'd15, 64'h102, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/culsans_axi_sram_slave.md
CULSANS_AXI_SRAM_SLAVE -- requirements
Module: culsans_axi_sram_slave

Interface
REQ-001 SHALL have parameter NumWords, default 512, meaning the number of 64-bit storage words (power of two, at least 2).
REQ-002 SHALL have parameter BaseAddr, default 64'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port axi_req_i, input, culsans_pkg::req_slv_t: AXI4 request from the crossbar (6-bit IDs with NB_CORES=2, 64-bit addr/data).
REQ-006 SHALL have port axi_resp_o, output, culsans_pkg::resp_slv_t: AXI4 response to the crossbar.

Function
REQ-007 SHALL implement FSM states IDLE, WDATA, WRESP and RDATA, serving one transaction at a time.
REQ-008 In IDLE, aw_ready and ar_ready SHALL be 1 and w_ready, b_valid and r_valid SHALL be 0; in all other states aw_ready and ar_ready SHALL be 0.
REQ-009 When aw_valid and ar_valid are both 1 in IDLE, SHALL grant the channel not granted last (alternating); the first grant after reset SHALL go to write; only the granted ready SHALL be 1 in that cycle.
REQ-010 On an AW or AR handshake, SHALL latch id, addr, len, size and burst, and move to WDATA or RDATA respectively.
REQ-011 Word index SHALL be (addr - BaseAddr) >> 3; a beat is in range when BaseAddr <= addr < BaseAddr + 8*NumWords.
REQ-012 The address SHALL be re-evaluated for every beat.
REQ-013 Address advance SHALL be: FIXED, unchanged; INCR, addr + (1 << size); WRAP, treated as INCR.
REQ-014 In WDATA, w_ready SHALL be 1; on each W handshake with an in-range address, SHALL write byte lanes where strb[i]=1; out-of-range beats SHALL be discarded and flag an error.
REQ-015 The W beat with last=1, or beat number len+1 (whichever comes first), SHALL end the burst and move to WRESP.
REQ-016 A last/len mismatch SHALL set the error flag.
REQ-017 In WRESP, b_valid SHALL be 1 with b.id = latched id and b.resp = SLVERR (2'b10) if any error was flagged, else OKAY.
REQ-018 b.user SHALL be 0.
REQ-019 b_valid SHALL hold stable until b_ready; on the handshake the FSM SHALL go to IDLE and clear the error flag.
REQ-020 R beats SHALL use combinational read of the current beat address; the first r_valid SHALL appear the cycle after the AR handshake (1-cycle latency).
REQ-021 In RDATA, r_valid SHALL be 1 with r.id = latched id, r.data = word (0 if out of range), r.resp = OKAY or SLVERR per beat, r.last = 1 on beat len, and r.user = 0.
REQ-022 The R payload SHALL hold stable while r_valid=1 and r_ready=0.
REQ-023 The beat counter SHALL advance only on an R handshake; on the last handshake the FSM SHALL go to IDLE.
REQ-024 Bursts SHALL support len up to 255 (256 beats); the 8-bit beat counter SHALL compare equal to len and SHALL NOT wrap.
REQ-025 The addr increment SHALL be a 64-bit add that wraps silently at 2^64; post-wrap beats are out of range.
REQ-026 The atop, lock, cache, prot, qos and region fields SHALL be ignored; the crossbar guarantees atop=0.
REQ-027 With NB_CORES=2, back-to-back transactions SHALL cost one IDLE cycle between them.

Reset
REQ-028 When rst_i=1 at a clock edge, SHALL enter IDLE, clear the error flag and beat counter, and set the last-grant to read, so that write wins first.
REQ-029 After reset, all valid/ready outputs SHALL reflect IDLE and payload fields SHALL be 0.
REQ-030 Reset in the middle of a burst SHALL abandon the transaction with no B or R emitted.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-032 Single write: AW addr=0x8000_0010, len=0, size=3, id=5; W data=0x1122334455667788, strb=0xFF, last=1 -> B id=5, OKAY; then AR to the same address -> R data=0x1122334455667788, last=1, first r_valid one cycle after AR.
REQ-033 INCR burst: write len=3 from 0x8000_0000 with data 0..3, then read len=3 with r_ready toggling every other cycle -> 4 beats 0,1,2,3 with r_valid and data stable while stalled, last only on beat 3.
REQ-034 Strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with strb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
REQ-035 Out of range: read len=1 starting at the last word (BaseAddr + 8*(NumWords-1)) -> beat 0 OKAY with data, beat 1 SLVERR with data 0; a write to BaseAddr-8 -> B SLVERR and memory unchanged.
REQ-036 Arbitration: AW and AR valid in the same IDLE cycle right after reset -> write granted; the next simultaneous request -> read granted.
REQ-037 Reset mid-burst: assert rst_i during beat 2 of a len=7 read -> next cycle IDLE with r_valid=0 and aw_ready=ar_ready=1; previously written data still readable.
